muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Multi-cycle signed multiply/divide unit with architectural HI/LO registers.
//  Sits downstream of the ALU-op decoder in EX stage; consumes ALUop codes
//  `ALU_MUL, `ALU_DIV, `ALU_MFHI (ALUop.vh); all other codes are for the single-cycle ALU.
//  Iterative radix-2 datapath; raises busy so the hazard unit stalls IF/ID/EX.
// PARAMETERS
//  WIDTH    32  operand/HI/LO width
//  ALUOP_W  4   ALUop code width
// PORTS
//  clk     in   1        clock, rising edge
//  rst     in   1        asynchronous reset, active-high
//  start   in   1        issue request, sampled with ALUop/a/b
//  ALUop   in   ALUOP_W  decoded operation
//  a       in   WIDTH    rs operand (multiplicand / dividend)
//  b       in   WIDTH    rt operand (multiplier / divisor)
//  busy    out  1        operation in progress; new starts ignored
//  done    out  1        one-cycle pulse: op complete, result/hi/lo valid
//  result  out  WIDTH    MUL: low product word; MFHI: HI; DIV: quotient (LO)
//  hi      out  WIDTH    HI register
//  lo      out  WIDTH    LO register
//  div0    out  1        sticky flag for last DIV: divisor was zero
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; busy,done,div0=0; result,hi,lo=0.
//    In-flight op discarded, no done pulse.
//  States: IDLE, CALC, FIX, DONE. busy=1 in CALC and FIX only.
//  Accept: start=1 in IDLE or DONE with ALUop in {MUL,DIV,MFHI}; other codes ignored.
//    start in CALC/FIX ignored (no queueing).
//  MUL/DIV: accept edge latches |a|, |b|, sign bits, op.
//    -> CALC for exactly WIDTH cycles (5-bit iteration counter 0..WIDTH-1).
//    -> FIX 1 cycle: two's-complement negation of results per signs.
//    -> DONE: hi/lo/result written on the edge entering DONE; done=1 for that cycle.
//    Latency: done asserted WIDTH+2 cycles after the accept edge (34 @32).
//  MUL: shift-add on 2*WIDTH accumulator. Product negated if sign(a)^sign(b).
//    {hi,lo}=full signed product; result=lo.
//  DIV: restoring shift-subtract. Quotient negated if sign(a)^sign(b);
//    remainder takes sign of a. lo=quotient, hi=remainder, result=quotient.
//  DIV b==0: same latency; lo=all ones, hi=a, div0=1. Any DIV with b!=0 clears div0.
//  DIV overflow (-2^(W-1) / -1): lo=0x80000000, hi=0, div0=0.
//  MFHI: accept -> DONE next cycle, no CALC/FIX; result=hi; hi/lo unchanged.
//  Back-to-back: start in DONE is accepted; done for the previous op still
//    pulses that cycle; new op's state entered next edge.
//  hi/lo change only on entry to DONE for MUL/DIV, or on reset.
// TESTING
//  1 rst mid-CALC of MUL -> immediate IDLE, busy=0, hi=lo=0, no done pulse.
//  2 MUL a=7 b=-3 -> done at +34 cycles; hi=0xFFFFFFFF lo=result=0xFFFFFFEB.
//  3 DIV a=-17 b=5 -> lo=0xFFFFFFFD hi=0xFFFFFFFE div0=0; then MFHI -> done next cycle, result=0xFFFFFFFE.
//  4 DIV a=9 b=0 -> at +34 lo=0xFFFFFFFF hi=9 div0=1; then DIV 0x80000000/-1 -> lo=0x80000000 hi=0 div0=0.
//  5 start MUL 2*3 at +5 of a running DIV (busy=1) -> ignored; DIV completes; hi/lo hold DIV values.
//  6 start DIV/MUL in DONE cycle, ALUop=`ALU_ADD start -> ignored (stays IDLE); back-to-back MULs -> two done pulses 34 apart.

Source files
------------

// File: rtl/muldiv_if.sv
// muldiv_if: issue/result bundle between the EX-stage decoder and muldiv_unit.
//   start, ALUop, a, b           : issue request (master -> slave)
//   busy, done, result, hi, lo,
//   div0                         : status and results (slave -> master)
interface muldiv_if #(
    parameter int WIDTH   = 32,
    parameter int ALUOP_W = 4
);
    logic               start;
    logic [ALUOP_W-1:0] ALUop;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   result;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic               div0;

    modport master (
        output start, ALUop, a, b,
        input  busy, done, result, hi, lo, div0
    );

    modport slave (
        input  start, ALUop, a, b,
        output busy, done, result, hi, lo, div0
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed multiply/divide with architectural HI/LO.
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-high
//   bus  : muldiv_if slave
//          start/ALUop/a/b issue a MUL, DIV or MFHI (other codes ignored)
//          busy   high while a MUL/DIV is iterating; new starts ignored
//          done   one-cycle completion pulse
//          result MUL: low product, DIV: quotient, MFHI: HI
//          hi/lo  HI/LO registers, div0 sticky divide-by-zero flag of last DIV
// ALU_* codes must match the decoder's ALUop encoding.
module muldiv_unit #(
    parameter int                WIDTH    = 32,
    parameter int                ALUOP_W  = 4,
    parameter logic [ALUOP_W-1:0] ALU_MUL  = ALUOP_W'(3),
    parameter logic [ALUOP_W-1:0] ALU_DIV  = ALUOP_W'(4),
    parameter logic [ALUOP_W-1:0] ALU_MFHI = ALUOP_W'(5)
) (
    input logic      clk,
    input logic      rst,
    muldiv_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    // MUL: acc_hi = partial upper product, acc_lo = multiplier / low product.
    // DIV: acc_hi = partial remainder,     acc_lo = dividend / quotient.
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   opnd;       // |a| for MUL, |b| for DIV
    logic               op_div;
    logic               sign_a;
    logic               sign_b;
    logic               b_zero;
    logic [WIDTH-1:0]   result_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               div0_r;

    logic               op_valid;
    logic               accept;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        op_valid  = (bus.ALUop == ALU_MUL) || (bus.ALUop == ALU_DIV) ||
                    (bus.ALUop == ALU_MFHI);
        accept    = bus.start && op_valid && ((state == S_IDLE) || (state == S_DONE));
        abs_a     = bus.a[WIDTH-1] ? -bus.a : bus.a;
        abs_b     = bus.b[WIDTH-1] ? -bus.b : bus.b;
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        // Bit WIDTH set means the trial subtraction borrowed: restore.
        div_diff  = div_shift - {1'b0, opnd};
        prod_fix  = (sign_a ^ sign_b) ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        quot_fix  = (sign_a ^ sign_b) ? -acc_lo : acc_lo;
        rem_fix   = sign_a ? -acc_hi : acc_hi;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            op_div   <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            b_zero   <= 1'b0;
            result_r <= '0;
            hi_r     <= '0;
            lo_r     <= '0;
            div0_r   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        if (bus.ALUop == ALU_MFHI) begin
                            result_r <= hi_r;
                            state    <= S_DONE;
                        end else begin
                            op_div <= (bus.ALUop == ALU_DIV);
                            sign_a <= bus.a[WIDTH-1];
                            sign_b <= bus.b[WIDTH-1];
                            b_zero <= (bus.b == '0);
                            acc_hi <= '0;
                            acc_lo <= (bus.ALUop == ALU_DIV) ? abs_a : abs_b;
                            opnd   <= (bus.ALUop == ALU_DIV) ? abs_b : abs_a;
                            cnt    <= '0;
                            state  <= S_CALC;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    if (op_div) begin
                        if (!div_diff[WIDTH]) begin
                            acc_hi <= div_diff[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_hi <= div_shift[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (op_div) begin
                        // Zero divisor: quotient bits all set, remainder is |a|,
                        // so the signed remainder already equals a.
                        lo_r     <= b_zero ? '1 : quot_fix;
                        result_r <= b_zero ? '1 : quot_fix;
                        hi_r     <= rem_fix;
                        div0_r   <= b_zero;
                    end else begin
                        hi_r     <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_r     <= prod_fix[WIDTH-1:0];
                        result_r <= prod_fix[WIDTH-1:0];
                    end
                    state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy   = (state == S_CALC) || (state == S_FIX);
    assign bus.done   = (state == S_DONE);
    assign bus.result = result_r;
    assign bus.hi     = hi_r;
    assign bus.lo     = lo_r;
    assign bus.div0   = div0_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random stimulus for muldiv_unit, checked
// every cycle against a latency/arithmetic model of the unit.
module tb_muldiv_unit;
    localparam int          W       = 32;
    localparam int          LAT     = W + 2;
    localparam logic [3:0]  OP_ADD  = 4'd0;
    localparam logic [3:0]  OP_MUL  = 4'd3;
    localparam logic [3:0]  OP_DIV  = 4'd4;
    localparam logic [3:0]  OP_MFHI = 4'd5;

    logic clk;
    logic rst;
    int   n_err;
    int   n_checks;

    muldiv_if #(.WIDTH(W), .ALUOP_W(4)) bus ();

    muldiv_unit #(
        .WIDTH   (W),
        .ALUOP_W (4),
        .ALU_MUL (OP_MUL),
        .ALU_DIV (OP_DIV),
        .ALU_MFHI(OP_MFHI)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_k: cycles since the accepting edge (0 = nothing in flight);
    // the op's done cycle is m_k == m_lat.
    int          m_k;
    int          m_lat;
    logic [31:0] m_hi, m_lo, m_res;
    logic        m_div0;
    logic [31:0] p_hi, p_lo, p_res;
    logic        p_div0, p_is_div;

    initial begin
        m_k = 0; m_lat = 0; m_hi = '0; m_lo = '0; m_res = '0; m_div0 = 1'b0;
        p_hi = '0; p_lo = '0; p_res = '0; p_div0 = 1'b0; p_is_div = 1'b0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_k = 0; m_lat = 0; m_hi = '0; m_lo = '0; m_res = '0; m_div0 = 1'b0;
            end else if ((m_k == 0 || m_k == m_lat) && bus.start &&
                         (bus.ALUop == OP_MUL || bus.ALUop == OP_DIV || bus.ALUop == OP_MFHI)) begin
                m_k = 1;
                if (bus.ALUop == OP_MFHI) begin
                    m_lat = 1;
                    m_res = m_hi;
                end else begin
                    m_lat = LAT;
                    if (bus.ALUop == OP_MUL) begin
                        longint pr;
                        pr = longint'($signed(bus.a)) * longint'($signed(bus.b));
                        p_hi = pr[63:32]; p_lo = pr[31:0]; p_is_div = 1'b0;
                    end else begin
                        p_is_div = 1'b1;
                        if (bus.b == 0) begin
                            p_lo = 32'hFFFF_FFFF; p_hi = bus.a; p_div0 = 1'b1;
                        end else if (bus.a == 32'h8000_0000 && bus.b == 32'hFFFF_FFFF) begin
                            p_lo = 32'h8000_0000; p_hi = 32'h0; p_div0 = 1'b0;
                        end else begin
                            int sa, sb;
                            sa = $signed(bus.a); sb = $signed(bus.b);
                            p_lo = sa / sb; p_hi = sa % sb; p_div0 = 1'b0;
                        end
                    end
                    p_res = p_lo;
                end
            end else if (m_k != 0) begin
                if (m_k == m_lat) begin
                    m_k = 0;
                end else begin
                    m_k++;
                    if (m_k == m_lat) begin
                        m_hi = p_hi; m_lo = p_lo; m_res = p_res;
                        if (p_is_div) m_div0 = p_div0;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            chk("busy", 64'(bus.busy), 64'((m_k != 0) && (m_k < m_lat)));
            chk("done", 64'(bus.done), 64'((m_k != 0) && (m_k == m_lat)));
            chk("hi", 64'(bus.hi), 64'(m_hi));
            chk("lo", 64'(bus.lo), 64'(m_lo));
            chk("div0", 64'(bus.div0), 64'(m_div0));
            if (m_k != 0 && m_k == m_lat) chk("result", 64'(bus.result), 64'(m_res));
        end
    end

    // ---------------- stimulus ----------------
    // All drives happen 1 time unit after a rising edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1; bus.ALUop = op; bus.a = a; bus.b = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int from, output int cyc);
        cyc = from;
        while (bus.done !== 1'b1 && cyc < 80) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic run_op(input string name, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int lat,
                          input logic [31:0] e_hi, input logic [31:0] e_lo,
                          input logic [31:0] e_res, input logic e_div0);
        int cyc;
        issue(op, a, b);
        wait_done(1, cyc);
        chk({name, "_latency"}, 64'(cyc), 64'(lat));
        chk({name, "_hi"}, 64'(bus.hi), 64'(e_hi));
        chk({name, "_lo"}, 64'(bus.lo), 64'(e_lo));
        chk({name, "_result"}, 64'(bus.result), 64'(e_res));
        chk({name, "_div0"}, 64'(bus.div0), 64'(e_div0));
    endtask

    initial begin
        int cyc;
        int pulses;
        n_err = 0; n_checks = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.ALUop = OP_ADD; bus.a = '0; bus.b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 64'(bus.busy), 64'(0));
        chk("reset_done", 64'(bus.done), 64'(0));
        chk("reset_hilo", {bus.hi, bus.lo}, 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset in the middle of a MUL
        issue(OP_MUL, 32'd5, 32'd6);
        repeat (9) begin @(posedge clk); #1; end
        chk("pre_rst_busy", 64'(bus.busy), 64'(1));
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_hilo", {bus.hi, bus.lo}, 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        pulses = 0;
        repeat (40) begin @(posedge clk); #1; if (bus.done) pulses++; end
        chk("rst_no_done", 64'(pulses), 64'(0));

        // MUL 7 * -3
        run_op("mul7x-3", OP_MUL, 32'd7, 32'hFFFF_FFFD, LAT,
               32'hFFFF_FFFF, 32'hFFFF_FFEB, 32'hFFFF_FFEB, 1'b0);
        chk("model_mul_hi", 64'(m_hi), 64'(32'hFFFF_FFFF));
        chk("model_mul_lo", 64'(m_lo), 64'(32'hFFFF_FFEB));

        // DIV -17 / 5, then MFHI issued in the DONE cycle
        run_op("div-17/5", OP_DIV, 32'hFFFF_FFEF, 32'd5, LAT,
               32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 1'b0);
        chk("model_div_hi", 64'(m_hi), 64'(32'hFFFF_FFFE));
        run_op("mfhi", OP_MFHI, 32'd0, 32'd0, 1,
               32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 1'b0);

        // Divide by zero, then the overflow case clears div0
        run_op("div9/0", OP_DIV, 32'd9, 32'd0, LAT,
               32'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        chk("model_div0", 64'(m_div0), 64'(1));
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, LAT,
               32'h0, 32'h8000_0000, 32'h8000_0000, 1'b0);
        repeat (3) begin @(posedge clk); #1; end

        // Start while busy is ignored
        issue(OP_DIV, 32'd100, 32'd7);
        repeat (4) begin @(posedge clk); #1; end
        chk("busy_at_5", 64'(bus.busy), 64'(1));
        issue(OP_MUL, 32'd2, 32'd3);
        wait_done(6, cyc);
        chk("busy_start_latency", 64'(cyc), 64'(LAT));
        chk("busy_start_hi", 64'(bus.hi), 64'(2));
        chk("busy_start_lo", 64'(bus.lo), 64'(14));

        // Non-muldiv code in the DONE cycle and in IDLE is ignored
        issue(OP_ADD, 32'd1, 32'd1);
        chk("add_in_done_busy", 64'(bus.busy), 64'(0));
        chk("add_in_done_done", 64'(bus.done), 64'(0));
        issue(OP_ADD, 32'd1, 32'd1);
        chk("add_idle_busy", 64'(bus.busy), 64'(0));

        // Back-to-back MULs
        run_op("mul_b2b_1", OP_MUL, 32'd1000, 32'd1000, LAT,
               32'd0, 32'd1000000, 32'd1000000, 1'b0);
        run_op("mul_b2b_2", OP_MUL, 32'h8000_0000, 32'h8000_0000, LAT,
               32'h4000_0000, 32'h0, 32'h0, 1'b0);
        repeat (2) begin @(posedge clk); #1; end

        // Random traffic; the per-cycle compare checks everything
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 9);
            bus.start = ($urandom_range(0, 9) < 3);
            bus.ALUop = (r < 4) ? OP_MUL : (r < 7) ? OP_DIV : (r == 7) ? OP_MFHI :
                        (r == 8) ? OP_ADD : 4'($urandom_range(6, 15));
            case ($urandom_range(0, 7))
                0: begin bus.a = 32'h8000_0000; bus.b = 32'hFFFF_FFFF; end
                1: begin bus.a = $urandom; bus.b = 32'h0; end
                2: begin bus.a = $urandom_range(0, 200) - 100; bus.b = $urandom_range(0, 20) - 10; end
                default: begin bus.a = $urandom; bus.b = $urandom; end
            endcase
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        repeat (40) begin @(posedge clk); #1; end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
